// File: rtl/arm_shift_branch_unit_pkg.sv
// arm_shift_branch_unit_pkg: shared encodings and condition evaluation for the shift/branch unit
package arm_shift_branch_unit_pkg;
  typedef enum logic [1:0] {
    AM_ROT_IMM   = 2'b00,
    AM_REG       = 2'b01,
    AM_OFFSET12  = 2'b10,
    AM_SHIFT_IMM = 2'b11
  } am_e;
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_e;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  function automatic logic cond_pass(input logic [3:0] cond, input logic n, input logic z,
                                     input logic c, input logic v);
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/arm_barrel_shift.sv
// arm_barrel_shift: combinational shifter operand generator, no carry-out
module arm_barrel_shift
  import arm_shift_branch_unit_pkg::*;
(
  input  logic [31:0] rm,
  input  logic [11:0] imm12,
  input  logic [1:0]  am,
  output logic [31:0] shifted
);
  logic [31:0] imm8;
  logic [4:0]  rot;
  logic [4:0]  amt;
  logic [31:0] rot_imm;
  logic [31:0] sh_imm;
  assign imm8 = {24'd0, imm12[7:0]};
  assign rot  = {imm12[11:8], 1'b0};
  assign amt  = imm12[11:7];
  assign rot_imm = (imm8 >> rot) | (imm8 << (6'd32 - {1'b0, rot}));
  // Shift by amount 0 falls out as rm for every type; the 32-bit left term vanishes.
  always_comb begin
    sh_imm = (imm12[6:5] == LSL) ? rm << amt :
             (imm12[6:5] == LSR) ? rm >> amt :
             (imm12[6:5] == ASR) ? $unsigned($signed(rm) >>> amt) :
                                   (rm >> amt) | (rm << (6'd32 - {1'b0, amt}));
  end
  // Addressing-mode select of the final operand.
  always_comb begin
    shifted = (am == AM_ROT_IMM)  ? rot_imm :
              (am == AM_REG)      ? rm :
              (am == AM_OFFSET12) ? {20'd0, imm12} :
                                    sh_imm;
  end
endmodule

// File: rtl/arm_shift_branch_unit.sv
// arm_shift_branch_unit: pc increment, shifter operand, flag register and branch decision
module arm_shift_branch_unit
  import arm_shift_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic [31:0] rm,
  input  logic [11:0] imm12,
  input  logic [1:0]  am,
  output logic [31:0] shifted,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        flag_update,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  input  logic [31:0] instruction,
  output logic        branch,
  output logic        branch_link
);
  logic unused_ok;
  assign unused_ok = ^instruction[23:0];
  assign next_pc = pc + 32'd4;
  arm_barrel_shift u_shift (
    .rm      (rm),
    .imm12   (imm12),
    .am      (am),
    .shifted (shifted)
  );
  // Flag register: cleared asynchronously, loaded from EX when requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {n, z, c, v} <= 4'b0000;
    else if (flag_update) {n, z, c, v} <= {n_in, z_in, c_in, v_in};
  end
  // Branch decision uses only the registered flags.
  always_comb begin
    branch      = (instruction[27:25] == 3'b101) && cond_pass(instruction[31:28], n, z, c, v);
    branch_link = branch && instruction[24];
  end
endmodule

// File: tb/tb_arm_shift_branch_unit.sv
// tb_arm_shift_branch_unit: directed-vector self-checking bench
module tb_arm_shift_branch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, next_pc, rm, shifted, instruction;
  logic [11:0] imm12;
  logic [1:0]  am;
  logic        n_in, z_in, c_in, v_in, flag_update;
  logic        n, z, c, v, branch, branch_link;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  arm_shift_branch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc), .rm(rm), .imm12(imm12),
    .am(am), .shifted(shifted), .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .flag_update(flag_update), .n(n), .z(z), .c(c), .v(v), .instruction(instruction),
    .branch(branch), .branch_link(branch_link)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic shift_chk(input string tag, input logic [1:0] a, input logic [31:0] r,
                           input logic [11:0] i, input logic [31:0] exp);
    am = a; rm = r; imm12 = i;
    #1 chk(tag, shifted, exp);
  endtask

  task automatic br_chk(input string tag, input logic [31:0] ins, input logic eb, input logic el);
    instruction = ins;
    #1 chk(tag, {30'd0, branch, branch_link}, {30'd0, eb, el});
  endtask

  initial begin
    reset = 1'b0; pc = 32'd0; rm = 32'd0; imm12 = 12'd0; am = 2'b00;
    {n_in, z_in, c_in, v_in} = 4'b1111; flag_update = 1'b1; instruction = 32'd0;
    @(posedge clk); #1;
    chk("reset_flags", {28'd0, n, z, c, v}, 32'h0);
    chk("pc_zero", next_pc, 32'h4);
    pc = 32'hFFFF_FFFC;
    #1 chk("pc_wrap", next_pc, 32'h0);
    shift_chk("rot_imm_4ff", 2'b00, 32'h0, 12'h4FF, 32'hFF00_0000);
    shift_chk("rot_imm_0", 2'b00, 32'h0, 12'h001, 32'h0000_0001);
    shift_chk("offset12", 2'b10, 32'h0, 12'hABC, 32'h0000_0ABC);
    shift_chk("reg", 2'b01, 32'h1234_5678, 12'hFFF, 32'h1234_5678);
    shift_chk("asr4", 2'b11, 32'h8000_0000, 12'h240, 32'hF800_0000);
    shift_chk("lsr4", 2'b11, 32'h8000_0000, 12'h220, 32'h0800_0000);
    shift_chk("ror4", 2'b11, 32'h0000_000F, 12'h260, 32'hF000_0000);
    shift_chk("lsl1", 2'b11, 32'h4000_0001, 12'h080, 32'h8000_0002);
    shift_chk("asr0", 2'b11, 32'h8000_0000, 12'h040, 32'h8000_0000);
    shift_chk("ror0", 2'b11, 32'h8765_4321, 12'h060, 32'h8765_4321);
    br_chk("bl_al_rst", 32'hEB00_0004, 1'b1, 1'b1);
    br_chk("add_rst", 32'hE081_0002, 1'b0, 1'b0);
    br_chk("nv_rst", 32'hFA00_0000, 1'b0, 1'b0);
    br_chk("beq_rst", 32'h0A00_0002, 1'b0, 1'b0);
    br_chk("bne_rst", 32'h1A00_0002, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0100; flag_update = 1'b1;
    @(posedge clk); #1;
    chk("load_z", {28'd0, n, z, c, v}, 32'h4);
    br_chk("beq", 32'h0A00_0002, 1'b1, 1'b0);
    br_chk("blne", 32'h1B00_0002, 1'b0, 1'b0);
    @(negedge clk);
    flag_update = 1'b0; {n_in, z_in, c_in, v_in} = 4'b1011;
    @(posedge clk); #1;
    chk("hold", {28'd0, n, z, c, v}, 32'h4);
    @(negedge clk);
    flag_update = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1111;
    #1 br_chk("no_bypass", 32'h4A00_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("load_all", {28'd0, n, z, c, v}, 32'hF);
    br_chk("ge", 32'hAA00_0000, 1'b1, 1'b0);
    br_chk("lt", 32'hBB00_0000, 1'b0, 1'b0);
    br_chk("hi", 32'h8A00_0000, 1'b0, 1'b0);
    br_chk("ls_link", 32'h9B00_0000, 1'b1, 1'b1);
    br_chk("gt", 32'hCA00_0000, 1'b0, 1'b0);
    br_chk("le", 32'hDA00_0000, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("async_clear", {28'd0, n, z, c, v}, 32'h0);
    @(posedge clk); #1;
    chk("upd_ignored", {28'd0, n, z, c, v}, 32'h0);
    @(negedge clk);
    reset = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0010;
    @(posedge clk); #1;
    chk("post_release", {28'd0, n, z, c, v}, 32'h2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
